// File: rtl/hazard_scoreboard_unit_if.sv
// Bundles the ID/EX hazard-check inputs and the pipeline-control outputs of hazard_scoreboard_unit.
// Latency: none (wires only).
// Backpressure: none here; the unit's stall output is the backpressure towards PC and IF/ID.
// Ports: id_valid/id_inst (ID stage), ex_valid/ex_memread/ex_regwrite/ex_rd (EX stage), flush,
//        stall/pc_we/ifid_we/idex_bubble/ifid_flush (control), busy/stall_count (status).
interface hazard_scoreboard_unit_if #(
  parameter int XLEN        = 32,
  parameter int RA          = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic [XLEN-1:0]        id_inst;
  logic                   ex_valid;
  logic                   ex_memread;
  logic                   ex_regwrite;
  logic [RA-1:0]          ex_rd;
  logic                   flush;
  logic                   stall;
  logic                   pc_we;
  logic                   ifid_we;
  logic                   idex_bubble;
  logic                   ifid_flush;
  logic                   busy;
  logic [STALL_CNT_W-1:0] stall_count;

  // Pipeline side drives the stage information and consumes the controls.
  modport master (
    output id_valid, id_inst, ex_valid, ex_memread, ex_regwrite, ex_rd, flush,
    input  stall, pc_we, ifid_we, idex_bubble, ifid_flush, busy, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_inst, ex_valid, ex_memread, ex_regwrite, ex_rd, flush,
    output stall, pc_we, ifid_we, idex_bubble, ifid_flush, busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard unit with a per-register countdown scoreboard for multi-cycle loads.
// Latency: control outputs are combinational (zero cycles); busy/stall_count are registered.
// Backpressure: stall freezes PC and IF/ID and bubbles ID/EX; flush overrides stall.
// Ports: clk, rst (sync, active high), bus (slave modport of hazard_scoreboard_unit_if).
module hazard_scoreboard_unit #(
  parameter int XLEN        = 32,
  parameter int NREG        = 32,
  parameter int RA          = 5,
  parameter int LOAD_LAT    = 1,
  parameter int LAT_W       = 3,
  parameter int STALL_CNT_W = 16,
  parameter int USE_DECODE  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  hazard_scoreboard_unit_if.slave     bus
);

  logic [6:0]             opcode;
  logic [RA-1:0]          rs1;
  logic [RA-1:0]          rs2;
  logic                   use_rs1;
  logic                   use_rs2;
  logic                   issue;
  logic                   waw_kill;
  logic                   hit_rs1;
  logic                   hit_rs2;
  logic                   stall;
  logic                   busy;
  logic [LAT_W-1:0]       cnt [NREG];
  logic [STALL_CNT_W-1:0] stall_count;
  logic                   unused_inst_bits;

  assign opcode = bus.id_inst[6:0];
  assign rs1    = bus.id_inst[19:15];
  assign rs2    = bus.id_inst[24:20];
  assign unused_inst_bits = ^{bus.id_inst[XLEN-1:25], bus.id_inst[14:7]};

  // Which sources the ID instruction really reads; immediates sitting in the
  // rs fields of U/J/I-type encodings must not create false hazards.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b1;
    if (USE_DECODE != 0) begin
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      case (opcode)
        7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end // OP
        7'b0100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end // STORE
        7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end // BRANCH
        7'b0010011: use_rs1 = 1'b1;                           // OP-IMM
        7'b0000011: use_rs1 = 1'b1;                           // LOAD
        7'b1100111: use_rs1 = 1'b1;                           // JALR
        default: ;
      endcase
    end
  end

  assign issue    = bus.ex_valid & bus.ex_memread & bus.ex_regwrite & (bus.ex_rd != '0);
  assign waw_kill = bus.ex_valid & bus.ex_regwrite & ~bus.ex_memread & (bus.ex_rd != '0);

  // The load still in EX has not yet reached the scoreboard, so it is matched
  // directly; older loads are covered by their nonzero counters.
  assign hit_rs1 = use_rs1 & (rs1 != '0) &
                   ((issue & (bus.ex_rd == rs1)) | (cnt[rs1] != '0));
  assign hit_rs2 = use_rs2 & (rs2 != '0) &
                   ((issue & (bus.ex_rd == rs2)) | (cnt[rs2] != '0));

  assign stall = bus.id_valid & ~bus.flush & (hit_rs1 | hit_rs2);

  // Entry 0 is held at zero so x0 never looks pending. EX keeps advancing
  // during a stall and flush never kills the older EX instruction, so neither
  // affects the scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (issue && (bus.ex_rd == RA'(r)))
          cnt[r] <= LAT_W'(LOAD_LAT - 1);
        else if (waw_kill && (bus.ex_rd == RA'(r)))
          cnt[r] <= '0;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (cnt[r] != '0) busy = 1'b1;
    end
  end

  // Saturating performance counter of stall cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

  assign bus.stall       = stall;
  assign bus.pc_we       = ~stall;
  assign bus.ifid_we     = ~stall;
  assign bus.idex_bubble = stall | bus.flush;
  assign bus.ifid_flush  = bus.flush;
  assign bus.busy        = busy;
  assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: three instances share one stimulus.
// u1: LOAD_LAT=1 decode on; u3: LOAD_LAT=3 decode on, 4-bit stall counter; u3l: LOAD_LAT=3 legacy.
// Inputs are driven just after the rising edge and outputs are sampled 1 time unit later.
module tb_hazard_scoreboard_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        ex_valid;
  logic        ex_memread;
  logic        ex_regwrite;
  logic [4:0]  ex_rd;
  logic        flush;

  int tests = 0;
  int fails = 0;
  int n;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.XLEN(32), .RA(5), .STALL_CNT_W(16)) if1 ();
  hazard_scoreboard_unit_if #(.XLEN(32), .RA(5), .STALL_CNT_W(4))  if3 ();
  hazard_scoreboard_unit_if #(.XLEN(32), .RA(5), .STALL_CNT_W(16)) if3l ();

  assign if1.id_valid = id_valid;     assign if3.id_valid = id_valid;     assign if3l.id_valid = id_valid;
  assign if1.id_inst = id_inst;       assign if3.id_inst = id_inst;       assign if3l.id_inst = id_inst;
  assign if1.ex_valid = ex_valid;     assign if3.ex_valid = ex_valid;     assign if3l.ex_valid = ex_valid;
  assign if1.ex_memread = ex_memread; assign if3.ex_memread = ex_memread; assign if3l.ex_memread = ex_memread;
  assign if1.ex_regwrite = ex_regwrite; assign if3.ex_regwrite = ex_regwrite; assign if3l.ex_regwrite = ex_regwrite;
  assign if1.ex_rd = ex_rd;           assign if3.ex_rd = ex_rd;           assign if3l.ex_rd = ex_rd;
  assign if1.flush = flush;           assign if3.flush = flush;           assign if3l.flush = flush;

  hazard_scoreboard_unit #(.LOAD_LAT(1), .STALL_CNT_W(16), .USE_DECODE(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  hazard_scoreboard_unit #(.LOAD_LAT(3), .STALL_CNT_W(4), .USE_DECODE(1))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  hazard_scoreboard_unit #(.LOAD_LAT(3), .STALL_CNT_W(16), .USE_DECODE(0))
    u3l (.clk(clk), .rst(rst), .bus(if3l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] s1, input logic [4:0] s2);
    return {7'd0, s2, s1, 3'd0, 5'd1, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic mr, input logic rw, input logic [4:0] rd);
    ex_valid = v; ex_memread = mr; ex_regwrite = rw; ex_rd = rd;
  endtask

  task automatic set_id(input logic v, input logic [31:0] inst);
    id_valid = v; id_inst = inst;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0;
    set_ex(0, 0, 0, 0); set_id(0, 32'h0);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_ex(0, 0, 0, 0); set_id(0, 32'h0);
    tick(); tick();
    // Outputs during reset with idle inputs
    chk("rst_stall", {31'd0, if1.stall}, 32'd0);
    chk("rst_pc_we", {31'd0, if1.pc_we}, 32'd1);
    chk("rst_ifid_we", {31'd0, if1.ifid_we}, 32'd1);
    chk("rst_bubble", {31'd0, if1.idex_bubble}, 32'd0);
    chk("rst_ifid_flush", {31'd0, if1.ifid_flush}, 32'd0);
    chk("rst_busy", {31'd0, if3.busy}, 32'd0);
    chk("rst_cnt", {16'd0, if1.stall_count}, 32'd0);
    rst = 1'b0;

    // LOAD_LAT=1: lw x5 in EX, add x6,x5,x7 in ID
    tick();
    set_ex(1, 1, 1, 5); set_id(1, enc(OP_R, 5, 7));
    #1;
    chk("l1_stall", {31'd0, if1.stall}, 32'd1);
    chk("l1_pc_we", {31'd0, if1.pc_we}, 32'd0);
    chk("l1_ifid_we", {31'd0, if1.ifid_we}, 32'd0);
    chk("l1_bubble", {31'd0, if1.idex_bubble}, 32'd1);
    tick();
    set_ex(0, 0, 0, 0);
    #1;
    chk("l1_release", {31'd0, if1.stall}, 32'd0);
    chk("l1_bubble_off", {31'd0, if1.idex_bubble}, 32'd0);
    chk("l1_count", {16'd0, if1.stall_count}, 32'd1);

    // LOAD_LAT=3, consumer directly after the load
    do_reset();
    set_id(1, enc(OP_R, 5, 0));
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) set_ex(1, 1, 1, 5); else set_ex(0, 0, 0, 0);
      #1;
      if (if3.stall) n++;
      if (i == 1) chk("l3_busy_after_issue", {31'd0, if3.busy}, 32'd1);
      tick();
    end
    chk("l3_stall_cycles", n, 3);
    chk("l3_count", {28'd0, if3.stall_count}, 32'd3);
    chk("l1_count_same_seq", {16'd0, if1.stall_count}, 32'd1);

    // LOAD_LAT=3, one independent instruction between load and consumer
    do_reset();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin set_ex(1, 1, 1, 5); set_id(1, enc(OP_R, 7, 8)); end
      else if (i == 1) begin set_ex(1, 0, 1, 6); set_id(1, enc(OP_R, 5, 0)); end
      else set_ex(0, 0, 0, 0);
      #1;
      if (if3.stall) n++;
      tick();
    end
    chk("l3_gap1_stall_cycles", n, 2);

    // x0 is never a hazard
    do_reset();
    set_ex(1, 1, 1, 0); set_id(1, enc(OP_R, 0, 0));
    #1;
    chk("x0_stall_l3", {31'd0, if3.stall}, 32'd0);
    chk("x0_stall_l3_legacy", {31'd0, if3l.stall}, 32'd0);
    // lui whose immediate bits alias rs1=x5
    set_ex(1, 1, 1, 5); set_id(1, enc(OP_LUI, 5, 0));
    #1;
    chk("lui_decode", {31'd0, if3.stall}, 32'd0);
    chk("lui_legacy", {31'd0, if3l.stall}, 32'd1);
    // addi with immediate aliasing rs2=x5: only legacy mode stalls
    set_id(1, enc(OP_I, 0, 5));
    #1;
    chk("addi_rs2_decode", {31'd0, if3.stall}, 32'd0);
    chk("addi_rs2_legacy", {31'd0, if3l.stall}, 32'd1);
    // store reads rs2
    set_id(1, enc(OP_S, 0, 5));
    #1;
    chk("store_rs2", {31'd0, if3.stall}, 32'd1);

    // WAW: addi x5 overwrites the pending load result
    do_reset();
    set_ex(1, 1, 1, 5); set_id(1, enc(OP_I, 0, 1));
    #1;
    chk("waw_addi_in_id", {31'd0, if3.stall}, 32'd0);
    tick();
    set_ex(1, 0, 1, 5); set_id(1, enc(OP_R, 7, 8));
    #1;
    chk("waw_busy_before_kill", {31'd0, if3.busy}, 32'd1);
    tick();
    set_ex(1, 0, 1, 6); set_id(1, enc(OP_R, 5, 5));
    #1;
    chk("waw_consumer_stall", {31'd0, if3.stall}, 32'd0);
    chk("waw_busy_cleared", {31'd0, if3.busy}, 32'd0);

    // Flush dominates stall
    do_reset();
    set_ex(1, 1, 1, 5); set_id(1, enc(OP_R, 5, 0)); flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, if3.stall}, 32'd0);
    chk("flush_bubble", {31'd0, if3.idex_bubble}, 32'd1);
    chk("flush_ifid_flush", {31'd0, if3.ifid_flush}, 32'd1);
    chk("flush_pc_we", {31'd0, if3.pc_we}, 32'd1);
    tick();
    flush = 1'b0; set_ex(0, 0, 0, 0); set_id(0, 32'h0);
    #1;
    chk("flush_count", {28'd0, if3.stall_count}, 32'd0);
    chk("flush_keeps_scoreboard", {31'd0, if3.busy}, 32'd1);
    set_id(1, enc(OP_R, 0, 5));
    #1;
    chk("flush_then_consumer", {31'd0, if3.stall}, 32'd1);

    // Reset during the second stall cycle
    do_reset();
    set_ex(1, 1, 1, 5); set_id(1, enc(OP_R, 5, 0));
    tick();
    set_ex(0, 0, 0, 0);
    #1;
    chk("mid_stall_2nd", {31'd0, if3.stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, if3.stall}, 32'd0);
    chk("mid_rst_busy", {31'd0, if3.busy}, 32'd0);
    chk("mid_rst_count", {28'd0, if3.stall_count}, 32'd0);

    // Saturation: 2^4+5 = 21 continuous stall cycles on the 4-bit counter
    do_reset();
    set_ex(1, 1, 1, 5); set_id(1, enc(OP_R, 5, 0));
    for (int i = 0; i < 21; i++) tick();
    set_ex(0, 0, 0, 0); set_id(0, 32'h0);
    #1;
    chk("sat_count_4b", {28'd0, if3.stall_count}, 32'd15);
    chk("sat_count_16b", {16'd0, if1.stall_count}, 32'd21);
    tick(); tick(); tick();
    chk("sat_hold_4b", {28'd0, if3.stall_count}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
